// File: rtl/sobel_pkg.sv
// ----------------------------------------------------------------------------
// sobel_pkg
// Shared constants for the line-buffer / window front end of the Sobel
// pipeline.
//   MAX_TAPS                : hard upper bound on vertical window height
//   MIN_TAPS                : lower bound on vertical window height
//   DEFAULT_MAX_LINE_WIDTH  : default line RAM depth (pixels)
//   DEFAULT_DATA_WIDTH      : default bits per pixel
//   DEFAULT_NUM_TAPS        : default vertical window height
// No ports (package).
// ----------------------------------------------------------------------------
package sobel_pkg;

   localparam int MAX_TAPS               = 8;
   localparam int MIN_TAPS               = 2;
   localparam int DEFAULT_MAX_LINE_WIDTH = 1920;
   localparam int DEFAULT_DATA_WIDTH     = 8;
   localparam int DEFAULT_NUM_TAPS       = 3;

   // Width of a row counter able to hold any row index 0..MAX_TAPS-1.
   localparam int ROW_CNT_W = $clog2(MAX_TAPS);

endpackage : sobel_pkg

// File: rtl/dp_ram.sv
// ----------------------------------------------------------------------------
// dp_ram
// Simple dual-port RAM: one synchronous write port, one asynchronous read
// port. A read at the address being written in the same cycle returns the
// old word (read-first), because the write only lands at the clock edge.
// Contents are not reset.
// Ports:
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// ----------------------------------------------------------------------------
module dp_ram #(
   parameter int DEPTH = 1920,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [0:DEPTH-1];

   // Write port: storage only, deliberately without reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule : dp_ram

// File: rtl/line_window_buf.sv
// ----------------------------------------------------------------------------
// line_window_buf
// Vertical window generator: keeps NUM_TAPS-1 previous lines in a chain of
// dp_ram instances and presents, for every accepted pixel, the column of
// NUM_TAPS pixels at that position (tap 0 = current pixel, tap k = pixel k
// lines above). Outputs are registered, one cycle after the accepted pixel.
//
// Optional feature (compile-time macro): LINE_WINDOW_BORDER_REPLICATE_EN
//   When defined, taps_valid is raised from row 0 of every frame and any tap
//   that reaches above the top of the image repeats the topmost real row.
//   When undefined, taps_valid stays low until the window is filled.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (priority over everything)
//   line_width : active pixels per line, sampled only on sof && data_valid
//   sof        : start of frame, qualified by data_valid
//   pixel_in   : incoming pixel
//   data_valid : pixel_in valid this cycle
//   taps_out   : window column, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   taps_valid : one-cycle pulse per accepted pixel once the window is usable
//   col_out    : column index of taps_out
//   eol_out    : taps_out is the last column of the line (only with taps_valid)
// ----------------------------------------------------------------------------
module line_window_buf
   import sobel_pkg::*;
#(
   parameter int MAX_LINE_WIDTH = DEFAULT_MAX_LINE_WIDTH,
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int NUM_TAPS       = DEFAULT_NUM_TAPS
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [$clog2(MAX_LINE_WIDTH):0]       line_width,
   input  logic                                  sof,
   input  logic [DATA_WIDTH-1:0]                 pixel_in,
   input  logic                                  data_valid,
   output logic [NUM_TAPS*DATA_WIDTH-1:0]        taps_out,
   output logic                                  taps_valid,
   output logic [$clog2(MAX_LINE_WIDTH)-1:0]     col_out,
   output logic                                  eol_out
);

   localparam int CW = $clog2(MAX_LINE_WIDTH);
   localparam int LW = CW + 1;

   localparam logic [LW-1:0]        MAXW_LW  = LW'(MAX_LINE_WIDTH);
   localparam logic [LW-1:0]        ONE_LW   = LW'(1'b1);
   localparam logic [CW-1:0]        ONE_CW   = CW'(1'b1);
   localparam logic [ROW_CNT_W-1:0] ROW_MAX  = ROW_CNT_W'(NUM_TAPS - 1);
   localparam logic [ROW_CNT_W-1:0] ONE_ROW  = ROW_CNT_W'(1'b1);

   // Position / geometry state.
   logic [CW-1:0]        col_r;
   logic [ROW_CNT_W-1:0] row_r;
   logic [LW-1:0]        active_width_r;

   // Effective values for the current cycle: sof overrides the counters and
   // the latched width so the sof pixel itself is column 0, row 0.
   logic [LW-1:0]        sof_width_s;
   logic [CW-1:0]        eff_col_s;
   logic [ROW_CNT_W-1:0] eff_row_s;
   logic [LW-1:0]        eff_width_s;
   logic                 last_col_s;
   logic                 out_valid_s;
   logic                 ram_we_s;

   // tap_s[0] is the live pixel, tap_s[k] the read of RAM k-1.
   logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] tap_s;
   logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] tap_sel_s;

   // Width clamp: 0 or anything larger than the RAM means "full width".
   always_comb begin
      sof_width_s = line_width;
      if ((line_width == {LW{1'b0}}) || (line_width > MAXW_LW)) begin
         sof_width_s = MAXW_LW;
      end else begin
         sof_width_s = line_width;
      end
   end

   // Effective column/row/width for this pixel, honouring sof.
   always_comb begin
      eff_col_s   = col_r;
      eff_row_s   = row_r;
      eff_width_s = active_width_r;
      if (sof) begin
         eff_col_s   = {CW{1'b0}};
         eff_row_s   = {ROW_CNT_W{1'b0}};
         eff_width_s = sof_width_s;
      end else begin
         eff_col_s   = col_r;
         eff_row_s   = row_r;
         eff_width_s = active_width_r;
      end
   end

   assign last_col_s = ({1'b0, eff_col_s} == (eff_width_s - ONE_LW));

   // RAM writes are suppressed while in reset so a reset cycle never
   // disturbs stored lines.
   assign ram_we_s = data_valid & ~rst;

   assign tap_s[0] = pixel_in;

   // Line store: RAM g holds the line g+1 above; each RAM writes back what
   // the previous RAM just read, shifting the column down the chain.
   for (genvar g = 0; g < NUM_TAPS - 1; g++) begin : g_line
      dp_ram #(
         .DEPTH (MAX_LINE_WIDTH),
         .WIDTH (DATA_WIDTH)
      ) u_ram (
         .clk   (clk),
         .we    (ram_we_s),
         .waddr (eff_col_s),
         .wdata (tap_s[g]),
         .raddr (eff_col_s),
         .rdata (tap_s[g+1])
      );
   end

`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
   logic [DATA_WIDTH-1:0] row_pix_s;

   // Border replication: taps above the top image row repeat tap[row].
   always_comb begin
      row_pix_s = {DATA_WIDTH{1'b0}};
      for (int j = 0; j < NUM_TAPS; j++) begin
         row_pix_s = row_pix_s |
                     ((eff_row_s == ROW_CNT_W'(j)) ? tap_s[j] : {DATA_WIDTH{1'b0}});
      end
      tap_sel_s    = tap_s;
      for (int k = 1; k < NUM_TAPS; k++) begin
         tap_sel_s[k] = (ROW_CNT_W'(k) > eff_row_s) ? row_pix_s : tap_s[k];
      end
   end

   assign out_valid_s = 1'b1;
`else
   assign tap_sel_s   = tap_s;
   assign out_valid_s = (eff_row_s == ROW_MAX);
`endif

   // Counters, latched width and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         taps_out       <= {(NUM_TAPS*DATA_WIDTH){1'b0}};
         taps_valid     <= 1'b0;
         col_out        <= {CW{1'b0}};
         eol_out        <= 1'b0;
         col_r          <= {CW{1'b0}};
         row_r          <= {ROW_CNT_W{1'b0}};
         active_width_r <= MAXW_LW;
      end else if (data_valid) begin
         taps_out       <= tap_sel_s;
         taps_valid     <= out_valid_s;
         col_out        <= eff_col_s;
         eol_out        <= out_valid_s & last_col_s;
         active_width_r <= eff_width_s;
         if (last_col_s) begin
            col_r <= {CW{1'b0}};
            row_r <= (eff_row_s == ROW_MAX) ? ROW_MAX : (eff_row_s + ONE_ROW);
         end else begin
            col_r <= eff_col_s + ONE_CW;
            row_r <= eff_row_s;
         end
      end else begin
         // Gap: everything holds except the per-pixel pulses.
         taps_valid <= 1'b0;
         eol_out    <= 1'b0;
      end
   end

endmodule : line_window_buf

// File: doc/line_window_buf.md
LINE_WINDOW_BUF -- requirements
Module: line_window_buf

Interface
REQ-001 SHALL have parameter MAX_LINE_WIDTH, default 1920: maximum pixels per line; sets RAM depth.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per pixel.
REQ-003 SHALL have parameter NUM_TAPS, default 3: rows in the vertical window, legal range 2..8.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port line_width, input, $clog2(MAX_LINE_WIDTH)+1 bits: active pixels per line; sampled at sof.
REQ-007 SHALL have port sof, input, 1 bit: start of frame; qualified by data_valid.
REQ-008 SHALL have port pixel_in, input, DATA_WIDTH bits: incoming pixel.
REQ-009 SHALL have port data_valid, input, 1 bit: pixel_in is valid this cycle.
REQ-010 SHALL have port taps_out, output, NUM_TAPS*DATA_WIDTH bits: vertical column, with tap k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port taps_valid, output, 1 bit: taps_out is valid and the window is filled.
REQ-012 SHALL have port col_out, output, $clog2(MAX_LINE_WIDTH) bits: column index of taps_out.
REQ-013 SHALL have port eol_out, output, 1 bit: taps_out is the last column of a line.

Function
REQ-014 SHALL store NUM_TAPS-1 lines as a chain of NUM_TAPS-1 dp_ram instances, each MAX_LINE_WIDTH deep.
REQ-015 SHALL have RAM k read at the column pointer and write back the value read from RAM k-1 (RAM 0 writes pixel_in), both only when data_valid.
REQ-016 SHALL set tap 0 = pixel_in, tap k = pixel from k lines earlier at the same column.
REQ-017 SHALL have a fixed latency of 1 cycle: taps_out, col_out and eol_out are registered, updating the cycle after an accepted pixel and holding otherwise.
REQ-018 SHALL keep a column counter that increments per accepted pixel and wraps to 0 after active_width-1.
REQ-019 SHALL keep a row counter that increments at each wrap and saturates at NUM_TAPS-1.
REQ-020 SHALL latch active_width from line_width when sof && data_valid; line_width is ignored at all other times.
REQ-021 SHALL treat a latched width of 0 or > MAX_LINE_WIDTH as MAX_LINE_WIDTH.
REQ-022 SHALL, on sof && data_valid, force both counters to 0 in the same cycle; that pixel is column 0, row 0, and any partial line is discarded.
REQ-023 SHALL pulse taps_valid for 1 cycle per accepted pixel once row count == NUM_TAPS-1; it is otherwise low.
REQ-024 SHALL set eol_out only with taps_valid, and only at column active_width-1.
REQ-025 SHALL use RAM read-first semantics (same-address read returns the old word); no bypass is needed because read and write addresses are identical.
REQ-026 SHALL hold all state while data_valid is low; gaps of any length inside a line are legal.

Reset
REQ-027 SHALL, on rst, clear taps_out, taps_valid, col_out, eol_out, column counter and row counter to 0, and set active_width to MAX_LINE_WIDTH.
REQ-028 SHALL leave RAM contents unreset; rst mid-line SHALL restart at column 0, row 0, with taps_valid low until NUM_TAPS-1 lines are refilled.
REQ-029 SHALL give rst priority over sof and data_valid.

Configuration
REQ-030 SHALL, with LINE_WINDOW_BORDER_REPLICATE_EN defined, raise taps_valid from row 0 of each frame, with each unfilled tap k (k > row) outputting tap[row], which replicates the top image border.
REQ-031 SHALL, with LINE_WINDOW_BORDER_REPLICATE_EN undefined, keep taps_valid low until the window fills (REQ-023), with no replication logic synthesised.

Structure
REQ-032 SHALL take MAX_TAPS = 8 and the default width/depth constants from package sobel_pkg.
REQ-033 SHALL reuse the existing dp_ram module unchanged as its only sub-module, instantiated in a generate loop.

Verification
REQ-034 SHALL verify: width 8, NUM_TAPS 3, 3 lines of ramp values r*16+c -> taps_valid first at line 2 col 0 with taps {0x00,0x10,0x20}; eol_out at col 7.
REQ-035 SHALL verify: data_valid toggling 1-0-0-1 inside a line -> outputs identical to gapless run, with taps_out held during gaps.
REQ-036 SHALL verify: sof at line 1 col 5 with line_width 4 -> counters reset; next taps_valid only after 2 full 4-pixel lines.
REQ-037 SHALL verify: line_width 0 at sof -> wrap after 1920 pixels, with eol_out at col 1919.
REQ-038 SHALL verify: rst asserted at line 3 col 2 -> all outputs 0 next cycle; taps_valid resumes after 2 new lines.
REQ-039 SHALL verify: with LINE_WINDOW_BORDER_REPLICATE_EN, first pixel 0x55 -> taps_valid 1 cycle later with taps {0x55,0x55,0x55}.
